// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles UART bytes into 32-bit words and writes them to instruction memory
module program_loader #(
    parameter int                   RAM_WIDTH  = 32,
    parameter int                   RAM_DEPTH  = 2048,
    parameter int                   ADDR_WIDTH = 11,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [RAM_WIDTH-1:0]  o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RECEIVE = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [RAM_WIDTH-1:0]  word_q, word_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [RAM_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [RAM_WIDTH-1:0]  shifted;

    // Big-endian: earlier bytes migrate towards the MSBs as later ones arrive
    assign shifted = {word_q[RAM_WIDTH-9:0], i_rx_data};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    state_d      = RECEIVE;
                    addr_d       = '0;
                    byte_cnt_d   = 2'd0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            RECEIVE: begin
                if (i_rx_done) begin
                    word_d = shifted;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = WRITE;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = shifted;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + CNT_ONE;
                if (wr_data_q == HALT_WORD) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d    = ERROR;
                    overflow_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    state_d = RECEIVE;
                    addr_d  = addr_q + ADDR_ONE;
                    // A strobe landing in the write cycle starts the next word
                    if (i_rx_done) begin
                        word_d     = shifted;
                        byte_cnt_d = 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            byte_cnt_q   <= 2'd0;
            word_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader (default and 4-deep instances)
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;

    logic        wr_en_b, busy_b, done_b, ovf_b;
    logic [10:0] wr_addr_b;
    logic [31:0] wr_data_b;
    logic [11:0] cnt_b;

    logic        wr_en_s, busy_s, done_s, ovf_s;
    logic [1:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [2:0]  cnt_s;

    int n_cmp = 0;
    int n_fail = 0;

    logic [42:0] wq_b[$];
    logic [33:0] wq_s[$];

    always #5 clk = ~clk;

    program_loader dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b), .o_busy(busy_b),
        .o_done(done_b), .o_overflow(ovf_b), .o_word_count(cnt_b)
    );

    program_loader #(.RAM_DEPTH(4), .ADDR_WIDTH(2)) dut_s (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_wr_en(wr_en_s), .o_wr_addr(wr_addr_s), .o_wr_data(wr_data_s), .o_busy(busy_s),
        .o_done(done_s), .o_overflow(ovf_s), .o_word_count(cnt_s)
    );

    always @(negedge clk) begin
        if (wr_en_b) wq_b.push_back({wr_addr_b, wr_data_b});
        if (wr_en_s) wq_s.push_back({wr_addr_s, wr_data_s});
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wq_b.delete();
        wq_s.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic send_words(input logic [31:0] words[$], input int max_gap);
        foreach (words[i])
            for (int k = 0; k < 4; k++)
                send_byte(words[i][31-8*k -: 8], $urandom_range(max_gap, 0));
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && !(done_b || ovf_b); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: word i goes to address i; loading stops on the halt word or at the last address
    task automatic model(input logic [31:0] words[$], input int depth,
                         output int n, output logic done, output logic ovf);
        n = 0; done = 1'b0; ovf = 1'b0;
        foreach (words[i]) begin
            n++;
            if (words[i] == 32'hFFFF_FFFF) begin done = 1'b1; break; end
            if (i == depth - 1) begin ovf = 1'b1; break; end
        end
    endtask

    task automatic check_against_model(input string tag, input logic [31:0] words[$]);
        int nb, ns;
        logic db, ob, ds, os;
        model(words, 2048, nb, db, ob);
        model(words, 4, ns, ds, os);
        n_cmp++;
        if (wq_b.size() != nb || done_b !== db || ovf_b !== ob || cnt_b !== 12'(nb)) begin
            n_fail++;
            $display("FAIL %s big: writes=%0d done=%b ovf=%b cnt=%0d required writes=%0d done=%b ovf=%b cnt=%0d",
                     tag, wq_b.size(), done_b, ovf_b, cnt_b, nb, db, ob, nb);
        end
        n_cmp++;
        if (wq_s.size() != ns || done_s !== ds || ovf_s !== os || cnt_s !== 3'(ns)) begin
            n_fail++;
            $display("FAIL %s small: writes=%0d done=%b ovf=%b cnt=%0d required writes=%0d done=%b ovf=%b cnt=%0d",
                     tag, wq_s.size(), done_s, ovf_s, cnt_s, ns, ds, os, ns);
        end
        for (int i = 0; i < nb && i < wq_b.size(); i++) begin
            n_cmp++;
            if (wq_b[i] !== {11'(i), words[i]}) begin
                n_fail++;
                $display("FAIL %s big write %0d: got %h required %h", tag, i, wq_b[i], {11'(i), words[i]});
            end
        end
        for (int i = 0; i < ns && i < wq_s.size(); i++) begin
            n_cmp++;
            if (wq_s[i] !== {2'(i), words[i]}) begin
                n_fail++;
                $display("FAIL %s small write %0d: got %h required %h", tag, i, wq_s[i], {2'(i), words[i]});
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b, ovf_b, cnt_b} !== '0 ||
            {wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, ovf_s, cnt_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: big=%h small=%h required 0",
                     {wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b, ovf_b, cnt_b},
                     {wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, ovf_s, cnt_s});
        end
        for (int k = 0; k < 4; k++) send_byte(8'h11 * (k + 1), 0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wq_b.size() != 0 || wq_s.size() != 0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_rx: writes=%0d/%0d busy=%b required 0/0 busy=0",
                     wq_b.size(), wq_s.size(), busy_b);
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] w[$] = '{32'h2008_0005, 32'hFFFF_FFFF};
        apply_reset();
        pulse_start();
        n_cmp++;
        if (busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b required 1", busy_b);
        end
        send_words(w, 1);
        settle();
        check_against_model("basic_load", w);
        n_cmp++;
        if (busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done: got %b required 0", busy_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C};
        apply_reset();
        pulse_start();
        send_words(w, 0);
        settle();
        check_against_model("back_to_back", w);
    endtask

    task automatic test_overflow();
        logic [31:0] w[$] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        apply_reset();
        pulse_start();
        send_words(w, 0);
        settle();
        for (int i = 0; i < 8 && !ovf_s; i++) @(posedge clk);
        #1;
        check_against_model("overflow", w);
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w[$] = '{32'hAABB_CCDD};
        apply_reset();
        pulse_start();
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        apply_reset();
        pulse_start();
        send_words(w, 0);
        settle();
        check_against_model("reset_mid_word", w);
    endtask

    task automatic test_reload();
        logic [31:0] w[$] = '{32'hFFFF_FFFF};
        logic [31:0] w2[$] = '{32'h1234_5678, 32'hFFFF_FFFF};
        apply_reset();
        pulse_start();
        send_words(w2, 0);
        settle();
        wq_b.delete();
        wq_s.delete();
        pulse_start();
        n_cmp++;
        if (done_b !== 1'b0 || busy_b !== 1'b1 || cnt_b !== 12'd0) begin
            n_fail++;
            $display("FAIL reload_rearm: done=%b busy=%b cnt=%0d required done=0 busy=1 cnt=0",
                     done_b, busy_b, cnt_b);
        end
        send_words(w, 2);
        settle();
        check_against_model("reload", w);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [31:0] w[$];
            int len = $urandom_range(7, 1);
            for (int i = 0; i < len; i++)
                w.push_back(($urandom_range(5, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
            apply_reset();
            pulse_start();
            send_words(w, $urandom_range(2, 0));
            settle();
            check_against_model($sformatf("random_%0d", it), w);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_reload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Program loader for the pipelined processor's instruction memory. It takes the byte stream delivered by the UART receiver, assembles every four bytes into one 32-bit instruction, and writes the instructions to consecutive instruction-memory addresses starting at 0. Loading ends when the halt word has been written or when memory overflows. It sits between the debug unit's UART receiver and the write port of the instruction memory, and it reports completion to the debug unit so the processor can be released.

## Interface
- `RAM_WIDTH`, 32: instruction width in bits.
- `RAM_DEPTH`, 2048: number of instruction-memory entries.
- `ADDR_WIDTH`, 11: write-address width; must equal clog2(`RAM_DEPTH`).
- `HALT_WORD`, 32'hFFFF_FFFF: word that ends the program.

Ports:
- `i_clk`  in  1  single clock; all logic is on the rising edge.
- `i_reset`  in  1  reset, synchronous and active-low (0 = reset).
- `i_start`  in  1  one-cycle request to arm the loader.
- `i_rx_data`  in  8  received byte.
- `i_rx_done`  in  1  one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_wr_en`  out  1  instruction-memory write enable.
- `o_wr_addr`  out  `ADDR_WIDTH`  write address.
- `o_wr_data`  out  `RAM_WIDTH`  write data.
- `o_busy`  out  1  high in RECEIVE and WRITE.
- `o_done`  out  1  program loaded; halt word written.
- `o_overflow`  out  1  memory filled without a halt word.
- `o_word_count`  out  `ADDR_WIDTH`+1  number of words written in the current load, including the halt word.

## Operation
- States: IDLE, RECEIVE, WRITE, DONE, ERROR.
- Reset (`i_reset`=0 at a clock edge):
  - state goes to IDLE; all outputs, the address counter, the byte counter and the word register go to 0.
  - This applies at any point, including mid-load; a partial word is discarded.
- IDLE: `i_rx_done` is ignored. `i_start`=1 moves to RECEIVE and clears the address, byte counter and `o_word_count`.
- RECEIVE: each `i_rx_done` shifts `i_rx_data` into the word register.
  - Byte order is big-endian: the 1st byte lands in [31:24], the 4th in [7:0].
  - The byte counter counts 0..3. The 4th byte moves to WRITE and resets the counter to 0.
- WRITE: lasts exactly one cycle.
  - `o_wr_en`=1, with `o_wr_addr` = current address and `o_wr_data` = assembled word.
  - `o_word_count` increments.
  - If the word equals `HALT_WORD`, go to DONE. The halt word is itself written.
  - Else, if the address equals `RAM_DEPTH`-1, go to ERROR.
  - Else, increment the address and go to RECEIVE.
- `i_rx_done` in the WRITE cycle:
  - The byte is not lost. It is captured as byte 1 of the next word, and the byte counter becomes 1.
  - If the transition is to DONE or ERROR, the byte is dropped.
- DONE: `o_done`=1 and is held. ERROR: `o_overflow`=1 and is held. In both states `i_rx_done` is ignored.
- `i_start`=1 in DONE or ERROR re-arms the loader, exactly as from IDLE. The `o_done`/`o_overflow` flag clears in the same edge.
- `i_start` in RECEIVE or WRITE is ignored.
- `i_reset` has priority over `i_start` and `i_rx_done` in the same cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `o_wr_en` is high for exactly one cycle per word. The memory samples the write on that cycle's edge.
- Latency: the 4th-byte strobe at edge n gives `o_wr_en`=1 during cycle n+1. `o_done` or `o_overflow` goes high from cycle n+2.
- `o_wr_addr` and `o_wr_data` are stable while `o_wr_en`=1. Outside WRITE they hold their last value, and are 0 after reset.
- `o_busy` rises the cycle after `i_start` is accepted. It falls in the same cycle that `o_done`/`o_overflow` rises.
- Throughput: one word per 4 strobes. Strobes may be back-to-back, one every cycle, with no loss.

## Test plan
- Reset values: assert `i_reset`=0 for 3 cycles, then release -> every output is 0 and the state is IDLE. Then 4 strobes without `i_start` -> no `o_wr_en`.
- Basic load: start, then bytes 20 08 00 05 and FF FF FF FF ->
  - write to addr 0 with data 32'h2008_0005;
  - write to addr 1 with data 32'hFFFF_FFFF;
  - `o_done`=1 and `o_word_count`=2.
- Back-to-back strobes: 12 consecutive-cycle strobes carrying bytes 01..0C ->
  - words 32'h01020304, 32'h05060708 and 32'h090A0B0C go to addrs 0, 1 and 2;
  - there are exactly 3 `o_wr_en` pulses and no byte is dropped.
- Overflow: with `RAM_DEPTH`=4, load 4 non-halt words ->
  - the 4th write goes to addr 3;
  - then `o_overflow`=1, `o_done`=0 and `o_word_count`=4.
- Reset mid-word: 2 bytes, reset, start, then 4 bytes AA BB CC DD -> a single write of 32'hAABBCCDD to addr 0.
- Reload: after DONE, pulse `i_start` and send one halt word -> `o_done` drops for the load, then returns; the write goes to addr 0 and `o_word_count`=1.
